// File: rtl/ivmisc_exu_pkg.sv
// Shared definitions for the ivmisc execution unit: op encodings, tag widths,
// stage payload layouts and the per-lane counting helpers.
package ivmisc_exu_pkg;

   localparam int XLEN   = 32;
   localparam int ROB_W  = 5;
   localparam int DEST_W = 6;

   // Bit 1 alone selects byte-select, so 2'b11 also decodes as OP_BSEL.
   typedef enum logic [1:0] {
      OP_CLZ  = 2'b00,
      OP_POPC = 2'b01,
      OP_BSEL = 2'b10
   } op_e;

   typedef struct packed {
      logic [1:0]        op;
      logic              size;
      logic [XLEN-1:0]   a;
      logic [XLEN-1:0]   b;
      logic [ROB_W-1:0]  rob;
      logic [DEST_W-1:0] dest;
   } e1_t;

   typedef struct packed {
      logic [XLEN-1:0]   result;
      logic [ROB_W-1:0]  rob;
      logic [DEST_W-1:0] dest;
   } e2_t;

   // Leading zeros of a 16-bit value; a byte lane pads its low half with ones.
   function automatic logic [4:0] clz16(input logic [15:0] x);
      logic [4:0] n;
      logic       seen;
      n    = 5'd0;
      seen = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (x[i]) seen = 1'b1;
         if (!seen) n = n + 5'd1;
      end
      return n;
   endfunction

   function automatic logic [4:0] popc16(input logic [15:0] x);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'b0000, x[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/ivmisc_exu_if.sv
// Issue / writeback / flush bundle between the scheduler side (master)
// and the ivmisc execution unit (slave).
interface ivmisc_exu_if;
   import ivmisc_exu_pkg::*;

   logic              flush_i;
   logic              issue_valid_i;
   logic              issue_ready_o;
   logic [1:0]        issue_op_i;
   logic              issue_size_i;
   logic [XLEN-1:0]   issue_a_i;
   logic [XLEN-1:0]   issue_b_i;
   logic [ROB_W-1:0]  issue_rob_i;
   logic [DEST_W-1:0] issue_dest_i;
   logic              wb_valid_o;
   logic              wb_ready_i;
   logic [XLEN-1:0]   wb_result_o;
   logic [ROB_W-1:0]  wb_rob_o;
   logic [DEST_W-1:0] wb_dest_o;
   logic              busy_o;

   modport slave (
      input  flush_i, issue_valid_i, issue_op_i, issue_size_i, issue_a_i,
             issue_b_i, issue_rob_i, issue_dest_i, wb_ready_i,
      output issue_ready_o, wb_valid_o, wb_result_o, wb_rob_o, wb_dest_o, busy_o
   );

   modport master (
      output flush_i, issue_valid_i, issue_op_i, issue_size_i, issue_a_i,
             issue_b_i, issue_rob_i, issue_dest_i, wb_ready_i,
      input  issue_ready_o, wb_valid_o, wb_result_o, wb_rob_o, wb_dest_o, busy_o
   );

endinterface

// File: rtl/ivmisc_exu_ivmisc.sv
// Combinational lane-wise misc ALU: clz, popcount and byte/halfword select
// over four 8-bit or two 16-bit lanes.
module ivmisc
   import ivmisc_exu_pkg::*;
(
   input  logic [1:0]      op,
   input  logic            size,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result
);

   logic [XLEN-1:0] clz_b, popc_b, bsel_b;
   logic [XLEN-1:0] clz_h, popc_h, bsel_h;
   logic            unused_b_bits;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte
         assign clz_b[8*gi +: 8]  = {3'b000, clz16({a[8*gi +: 8], 8'hFF})};
         assign popc_b[8*gi +: 8] = {3'b000, popc16({8'h00, a[8*gi +: 8]})};
         assign bsel_b[8*gi +: 8] = a[{b[8*gi +: 2], 3'b000} +: 8];
      end
      for (genvar gi = 0; gi < 2; gi++) begin : g_half
         assign clz_h[16*gi +: 16]  = {11'd0, clz16(a[16*gi +: 16])};
         assign popc_h[16*gi +: 16] = {11'd0, popc16(a[16*gi +: 16])};
         assign bsel_h[16*gi +: 16] = a[{b[16*gi], 4'b0000} +: 16];
      end
   endgenerate

   // Only the low index bits of each b lane participate in the select.
   assign unused_b_bits = ^{b[31:26], b[23:18], b[15:10], b[7:2]};

   always_comb begin
      result = '0;
      case (op)
         OP_CLZ:  result = size ? clz_h  : clz_b;
         OP_POPC: result = size ? popc_h : popc_b;
         default: result = size ? bsel_h : bsel_b;
      endcase
   end

endmodule

// File: rtl/ivmisc_exu.sv
// Two-stage ivmisc execution unit: E1 registers the issued op, E2 registers
// the datapath result; valid/ready handshake with flush and async reset.
module ivmisc_exu
   import ivmisc_exu_pkg::*;
(
   input  logic         cpu_clock_i,
   input  logic         cpu_reset_ni,
   ivmisc_exu_if.slave  bus
);

   e1_t             e1_reg;
   e2_t             e2_reg;
   logic            e1_valid_reg;
   logic            e2_valid_reg;
   logic            e1_adv;
   logic            e2_adv;
   logic            issue_ready;
   logic            accept;
   logic [XLEN-1:0] e1_result;

   assign e2_adv      = !e2_valid_reg | bus.wb_ready_i;
   assign e1_adv      = !e1_valid_reg | e2_adv;
   assign issue_ready = e1_adv & !bus.flush_i;
   assign accept      = bus.issue_valid_i & issue_ready;

   ivmisc u_ivmisc (
      .op     (e1_reg.op),
      .size   (e1_reg.size),
      .a      (e1_reg.a),
      .b      (e1_reg.b),
      .result (e1_result)
   );

   // Flush clears only the valid bits; payloads keep their last contents.
   always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
      if (!cpu_reset_ni) begin
         e1_valid_reg <= 1'b0;
         e2_valid_reg <= 1'b0;
         e1_reg       <= '0;
         e2_reg       <= '0;
      end else if (bus.flush_i) begin
         e1_valid_reg <= 1'b0;
         e2_valid_reg <= 1'b0;
      end else begin
         if (e2_adv) begin
            e2_valid_reg <= e1_valid_reg;
            if (e1_valid_reg) begin
               e2_reg.result <= e1_result;
               e2_reg.rob    <= e1_reg.rob;
               e2_reg.dest   <= e1_reg.dest;
            end
         end
         if (e1_adv) begin
            e1_valid_reg <= accept;
            if (accept) begin
               e1_reg.op   <= bus.issue_op_i;
               e1_reg.size <= bus.issue_size_i;
               e1_reg.a    <= bus.issue_a_i;
               e1_reg.b    <= bus.issue_b_i;
               e1_reg.rob  <= bus.issue_rob_i;
               e1_reg.dest <= bus.issue_dest_i;
            end
         end
      end
   end

   assign bus.issue_ready_o = issue_ready;
   assign bus.wb_valid_o    = e2_valid_reg;
   assign bus.wb_result_o   = e2_reg.result;
   assign bus.wb_rob_o      = e2_reg.rob;
   assign bus.wb_dest_o     = e2_reg.dest;
   assign bus.busy_o        = e1_valid_reg | e2_valid_reg;

endmodule

// File: doc/ivmisc_exu.md
IVMISC_EXU -- requirements
Module: ivmisc_exu

Interface
REQ-001 SHALL have port cpu_clock_i, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port cpu_reset_ni, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port flush_i, input, 1: synchronous kill of all in-flight ops.
REQ-004 SHALL have port issue_valid_i, input, 1: issue request.
REQ-005 SHALL have port issue_ready_o, output, 1: the unit accepts the op this cycle.
REQ-006 SHALL have port issue_op_i, input, 2: 00 clz, 01 popcount, 1x byte-select.
REQ-007 SHALL have port issue_size_i, input, 1: 0 = 8-bit lanes, 1 = 16-bit lanes.
REQ-008 SHALL have ports issue_a_i and issue_b_i, input, 32 each: operands.
REQ-009 SHALL have port issue_rob_i, input, 5: ROB tag, carried unchanged to writeback.
REQ-010 SHALL have port issue_dest_i, input, 6: physical destination register, carried unchanged.
REQ-011 SHALL have port wb_valid_o, output, 1: result available.
REQ-012 SHALL have port wb_ready_i, input, 1: writeback consumer takes the result.
REQ-013 SHALL have ports wb_result_o (32), wb_rob_o (5) and wb_dest_o (6), outputs.
REQ-014 SHALL have port busy_o, output, 1: any stage holds a valid op.

Function
REQ-015 SHALL accept an op only on a cycle where issue_valid_i and issue_ready_o are both high and flush_i is low.
REQ-016 SHALL implement two stages, each holding a valid bit plus payload: E1 holds the registered operands, op, size, rob and dest; E2 holds the registered result, rob and dest.
REQ-017 SHALL compute the E2 result combinationally from E1 contents through the ivmisc datapath.
REQ-018 SHALL take an accepted op from acceptance to wb_valid_o high in exactly 2 cycles when wb_ready_i is high.
REQ-019 SHALL with wb_ready_i held high, sustain one op per cycle with no bubbles.
REQ-020 SHALL define e2_adv = !e2_valid | wb_ready_i.
REQ-021 SHALL define e1_adv = !e1_valid | e2_adv.
REQ-022 SHALL drive issue_ready_o = e1_adv & !flush_i.
REQ-023 SHALL, when a stage does not advance, hold its payload bit-stable with wb_valid_o held high; no result is dropped or duplicated.
REQ-024 SHALL make the E2 write and the E2 consume in the same cycle (full pipeline, wb_ready_i high) replace E2 with the E1 result, with no bubble.
REQ-025 SHALL, on flush_i, clear e1_valid and e2_valid at the next edge regardless of wb_ready_i.
REQ-026 SHALL give flush_i priority over a simultaneous issue, which is not accepted.
REQ-027 SHALL leave payload registers unchanged by flush; only the valid bits clear.
REQ-028 SHALL drive wb_valid_o = e2_valid and busy_o = e1_valid | e2_valid.
REQ-029 SHALL pass rob and dest through bit-exact, and the result SHALL equal the ivmisc function of the same (a, b, op, size).

Reset
REQ-030 SHALL, while cpu_reset_ni is low, asynchronously force e1_valid=0 and e2_valid=0, giving wb_valid_o=0, busy_o=0 and issue_ready_o=1 (when flush_i is low).
REQ-031 SHALL reset the payload registers to zero (wb_result_o=0, wb_rob_o=0, wb_dest_o=0).
REQ-032 SHALL discard an op in flight when reset asserts, and SHALL NOT emit it after reset release.
REQ-033 SHALL allow the first accept on the first rising edge after cpu_reset_ni deasserts.

Structure
REQ-034 SHALL place the op encodings (CLZ=2'b00, POPC=2'b01, BSEL=2'b10) and the ROB/dest tag widths in the shared math package.
REQ-035 SHALL instantiate ivmisc as its one sub-module, between E1 and E2.
REQ-036 SHALL keep the handshake and valid logic in this module only.

Verification
REQ-037 SHALL cover: clz, size 0, a=0x000180FF -> wb_result_o=0x08070000, 2 cycles after accept.
REQ-038 SHALL cover: popcount, size 1, a=0xFFFF0001 -> 0x00100001; popcount, size 0, a=0x0F0301FF -> 0x04020108.
REQ-039 SHALL cover: byte-select, size 0, a=0x44332211, b=0x00010203 -> 0x11223344; rob=0x1F and dest=0x2A are echoed.
REQ-040 SHALL cover: issue 3 back-to-back ops with wb_ready_i low for 5 cycles -> issue_ready_o low after 2 accepts, third held off, then all 3 results in order, one per cycle, once ready rises.
REQ-041 SHALL cover: flush_i with both stages full and issue_valid_i high -> next cycle wb_valid_o=0, busy_o=0, issued op not accepted.
REQ-042 SHALL cover: cpu_reset_ni pulsed low mid-operation -> wb_valid_o drops immediately (asynchronous) and no stale result appears after release.
